binary_window_3x3: RTL and testbench

BINARY_WINDOW_3X3 -- requirements
Module: binary_window_3x3

---
 rtl/binary_window_3x3_pkg.sv | 14 +
 rtl/binary_window_3x3_pix_pos_counter.sv | 56 +++++
 rtl/binary_window_3x3.sv | 80 ++++++++
 tb/tb_binary_window_3x3.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/binary_window_3x3_pkg.sv
// rtl/binary_window_3x3_pkg.sv - shared constants and morphology helper for the 3x3 binary window
package binary_window_3x3_pkg;

    localparam int DEFAULT_WIDTH  = 800;
    localparam int DEFAULT_HEIGHT = 600;

    localparam logic MODE_ERODE  = 1'b0;
    localparam logic MODE_DILATE = 1'b1;

    function automatic logic morph(input logic [8:0] win, input logic mode);
        return (mode == MODE_DILATE) ? (|win) : (&win);
    endfunction

endpackage

// File: rtl/binary_window_3x3_pix_pos_counter.sv
// rtl/binary_window_3x3_pix_pos_counter.sv - column/row position tracking with start-of-frame resync
module pix_pos_counter
    import binary_window_3x3_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic                       clk,
    input  logic                       Reset_n,
    input  logic                       pix_valid,
    input  logic                       sof,
    output logic [$clog2(WIDTH)-1:0]   col,
    output logic [$clog2(HEIGHT)-1:0]  row,
    output logic                       last_col
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          sof_beat;

    // A start-of-frame beat is pixel (0,0) regardless of where the counters were.
    assign sof_beat = pix_valid & sof;
    assign col      = sof_beat ? '0 : col_q;
    assign row      = sof_beat ? '0 : row_q;
    assign last_col = (col == COL_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (pix_valid) begin
            if (last_col) begin
                col_d = '0;
                row_d = (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col_d = col + CW'(1);
                row_d = row;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/binary_window_3x3.sv
// rtl/binary_window_3x3.sv - 3x3 binary erode/dilate over a streamed, line-delayed pixel triple
module binary_window_3x3
    import binary_window_3x3_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int HEIGHT = DEFAULT_HEIGHT
) (
    input  logic clk,
    input  logic Reset_n,
    input  logic pix_valid,
    input  logic sof,
    input  logic row0,
    input  logic row1,
    input  logic row2,
    input  logic mode,
    output logic out_valid,
    output logic out_pix,
    output logic out_sof,
    output logic out_eol
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          last_col;

    pix_pos_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_pos (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .pix_valid (pix_valid),
        .sof       (sof),
        .col       (col),
        .row       (row),
        .last_col  (last_col)
    );

    // Only the two older columns need storage; the newest column is the live beat.
    logic [1:0] hist0_q, hist1_q, hist2_q;
    logic [2:0] win0_d, win1_d, win2_d;
    logic       produce;
    logic       out_valid_q, out_pix_q, out_sof_q, out_eol_q;

    assign win0_d  = {hist0_q, row0};
    assign win1_d  = {hist1_q, row1};
    assign win2_d  = {hist2_q, row2};
    assign produce = pix_valid && (row >= RW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            hist0_q     <= '0;
            hist1_q     <= '0;
            hist2_q     <= '0;
            out_valid_q <= 1'b0;
            out_pix_q   <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eol_q   <= 1'b0;
        end else begin
            if (pix_valid) begin
                hist0_q <= win0_d[1:0];
                hist1_q <= win1_d[1:0];
                hist2_q <= win2_d[1:0];
            end
            out_valid_q <= produce;
            out_pix_q   <= produce && morph({win2_d, win1_d, win0_d}, mode);
            out_sof_q   <= produce && (row == RW'(2)) && (col == CW'(2));
            out_eol_q   <= produce && last_col;
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_sof   = out_sof_q;
    assign out_eol   = out_eol_q;

endmodule

// File: tb/tb_binary_window_3x3.sv
// tb/tb_binary_window_3x3.sv - scoreboard bench for binary_window_3x3 at 8x6
module tb_binary_window_3x3;

    localparam int W = 8;
    localparam int H = 6;

    logic clk = 1'b0;
    logic Reset_n = 1'b0;
    logic pix_valid = 1'b0, sof = 1'b0, row0 = 1'b0, row1 = 1'b0, row2 = 1'b0, mode = 1'b0;
    logic out_valid, out_pix, out_sof, out_eol;

    binary_window_3x3 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk       (clk),
        .Reset_n   (Reset_n),
        .pix_valid (pix_valid),
        .sof       (sof),
        .row0      (row0),
        .row1      (row1),
        .row2      (row2),
        .mode      (mode),
        .out_valid (out_valid),
        .out_pix   (out_pix),
        .out_sof   (out_sof),
        .out_eol   (out_eol)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit pix;
        bit sof;
        bit eol;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   outs_seen = 0, ones_seen = 0, eol_seen = 0, sof_seen = 0;
    int   b_outs, b_ones, b_eol, b_sof;
    bit   img [H][W];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit model_pix(input int r, input int c, input bit m);
        bit a = 1'b1;
        bit o = 1'b0;
        for (int dr = 0; dr < 3; dr++)
            for (int dc = 0; dc < 3; dc++) begin
                a = a & img[r-dr][c-dc];
                o = o | img[r-dr][c-dc];
            end
        return m ? o : a;
    endfunction

    task automatic fill(input bit v);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = v;
    endtask

    task automatic beat(input int r, input int c, input bit s, input bit m);
        exp_t e;
        pix_valid = 1'b1;
        sof  = s;
        mode = m;
        row0 = img[r][c];
        row1 = (r >= 1) ? img[r-1][c] : 1'($urandom);
        row2 = (r >= 2) ? img[r-2][c] : 1'($urandom);
        if (r >= 2 && c >= 2) begin
            e.pix = model_pix(r, c, m);
            e.sof = (r == 2 && c == 2);
            e.eol = (c == W - 1);
            e.cyc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        sof = 1'b0;
    endtask

    task automatic gap();
        pix_valid = 1'b0;
        sof  = 1'($urandom);
        mode = 1'($urandom);
        row0 = 1'($urandom);
        row1 = 1'($urandom);
        row2 = 1'($urandom);
        @(posedge clk);
        #1;
        sof = 1'b0;
    endtask

    task automatic run_frame(input bit m, input bit toggle, input int flip_row,
                             input bit first_sof, input int stop_r, input int stop_c);
        bit mm;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                mm = (flip_row >= 0 && r >= flip_row) ? ~m : m;
                beat(r, c, first_sof && r == 0 && c == 0, mm);
                if (toggle) gap();
                if (r == stop_r && c == stop_c) return;
            end
    endtask

    task automatic snap();
        b_outs = outs_seen;
        b_ones = ones_seen;
        b_eol  = eol_seen;
        b_sof  = sof_seen;
    endtask

    task automatic verify(input string name, input int outs, input int ones,
                          input int eols, input int sofs);
        gap();
        gap();
        check({name, "_outputs"}, outs_seen - b_outs, outs);
        check({name, "_ones"}, ones_seen - b_ones, ones);
        check({name, "_eol_count"}, eol_seen - b_eol, eols);
        check({name, "_sof_count"}, sof_seen - b_sof, sofs);
        check({name, "_queue_drained"}, q.size(), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (Reset_n) begin
                if (out_valid) begin
                    outs_seen++;
                    ones_seen += int'(out_pix);
                    eol_seen  += int'(out_eol);
                    sof_seen  += int'(out_sof);
                    if (q.size() == 0) begin
                        check("unexpected_out_valid", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("out_pix", int'(out_pix), int'(e.pix));
                        check("out_sof", int'(out_sof), int'(e.sof));
                        check("out_eol", int'(out_eol), int'(e.eol));
                        check("out_cycle", cyc, e.cyc);
                    end
                end else begin
                    check("idle_outputs_zero", int'({out_pix, out_sof, out_eol}), 0);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_pix", int'(out_pix), 0);
        check("reset_out_sof", int'(out_sof), 0);
        check("reset_out_eol", int'(out_eol), 0);
        Reset_n = 1'b1;

        // First beat after reset counts as (0,0) even without sof.
        fill(1'b1);
        snap();
        run_frame(1'b0, 1'b0, -1, 1'b0, -1, -1);
        verify("ones_erode", 24, 24, 4, 1);

        fill(1'b0);
        img[3][4] = 1'b1;
        snap();
        run_frame(1'b1, 1'b0, -1, 1'b1, -1, -1);
        verify("dot_dilate", 24, 9, 4, 1);

        snap();
        run_frame(1'b0, 1'b0, -1, 1'b1, -1, -1);
        verify("dot_erode", 24, 0, 4, 1);

        // Dilate switches to erode at row 5: only producing rows 3 and 4 light up.
        snap();
        run_frame(1'b1, 1'b0, 5, 1'b1, -1, -1);
        verify("mode_switch", 24, 6, 4, 1);

        fill(1'b1);
        snap();
        run_frame(1'b0, 1'b1, -1, 1'b1, -1, -1);
        verify("toggle_valid", 24, 24, 4, 1);

        run_frame(1'b0, 1'b0, -1, 1'b1, 3, 5);
        Reset_n = 1'b0;
        #1;
        check("midreset_out_valid", int'(out_valid), 0);
        check("midreset_out_pix", int'(out_pix), 0);
        check("midreset_out_sof", int'(out_sof), 0);
        check("midreset_out_eol", int'(out_eol), 0);
        q.delete();
        @(posedge clk);
        #1;
        Reset_n = 1'b1;
        snap();
        run_frame(1'b0, 1'b0, -1, 1'b1, -1, -1);
        verify("after_reset", 24, 24, 4, 1);

        // Partial frame to (4,2), then sof at (4,3) restarts the frame.
        snap();
        run_frame(1'b0, 1'b0, -1, 1'b1, 4, 2);
        run_frame(1'b0, 1'b0, -1, 1'b1, -1, -1);
        verify("sof_resync", 37, 37, 6, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
